// File: rtl/mm_result_drain.sv
// Writeback drain for the 8x8 multiplier: snapshots all 64 results when done rises,
// then streams them over a valid/ready write port with a running checksum.
module mm_result_drain #(
    parameter int ADDR_W      = 16,
    parameter int ADDR_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2047:0]     c_in,
    input  logic              mm_done,
    input  logic              col_major,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              drain_busy,
    output logic              drain_done,
    output logic              overrun,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              done_q;
    logic              col_major_q;
    logic [ADDR_W-1:0] base_q;
    logic [5:0]        idx_q;
    logic [31:0]       buf_q [64];

    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              drain_busy_q;
    logic              drain_done_q;
    logic              overrun_q;
    logic [31:0]       checksum_q;

    logic              trigger;
    logic              capture_en;
    logic              accept;
    logic [5:0]        idx_d;
    logic [5:0]        elem_sel;
    logic [ADDR_W-1:0] addr_d;

    assign trigger    = mm_done & ~done_q;
    assign capture_en = trigger && (state_q == S_IDLE);
    assign accept     = wr_valid_q & wr_ready;

    // idx_d is the index of the word to present next: 0 out of CAPTURE, else idx+1.
    assign idx_d    = (state_q == S_CAPTURE) ? 6'd0 : idx_q + 6'd1;
    assign elem_sel = col_major_q ? {idx_d[2:0], idx_d[5:3]} : idx_d;
    assign addr_d   = base_q + ADDR_W'(idx_d) * ADDR_W'(ADDR_STRIDE);

    always_ff @(posedge clk) begin
        if (capture_en) begin
            for (int i = 0; i < 64; i++) begin
                buf_q[i] <= c_in[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b1;
            col_major_q  <= 1'b0;
            base_q       <= '0;
            idx_q        <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            drain_busy_q <= 1'b0;
            drain_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            checksum_q   <= '0;
        end else begin
            done_q <= mm_done;
            if (trigger && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (capture_en) begin
                        col_major_q  <= col_major;
                        base_q       <= base_addr;
                        idx_q        <= '0;
                        checksum_q   <= '0;
                        drain_busy_q <= 1'b1;
                        state_q      <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    wr_valid_q <= 1'b1;
                    wr_data_q  <= buf_q[elem_sel];
                    wr_addr_q  <= addr_d;
                    state_q    <= S_STREAM;
                end
                S_STREAM: begin
                    if (accept) begin
                        checksum_q <= checksum_q + wr_data_q;
                        if (idx_q == 6'd63) begin
                            wr_valid_q   <= 1'b0;
                            drain_busy_q <= 1'b0;
                            drain_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            idx_q     <= idx_d;
                            wr_data_q <= buf_q[elem_sel];
                            wr_addr_q <= addr_d;
                        end
                    end
                end
                S_DONE: begin
                    drain_done_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign drain_busy = drain_busy_q;
    assign drain_done = drain_done_q;
    assign overrun    = overrun_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_mm_result_drain.sv
// Randomised bench for mm_result_drain: a per-cycle reference model of the drain
// plus literal expectations for the hand-computable scenarios.
module tb_mm_result_drain;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2047:0] c_in = '0;
    logic          mm_done = 1'b1;
    logic          col_major = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          wr_ready = 1'b0;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          drain_busy;
    logic          drain_done;
    logic          overrun;
    logic [31:0]   checksum;

    mm_result_drain #(.ADDR_W(AW), .ADDR_STRIDE(4)) dut (
        .clk(clk), .rst(rst), .c_in(c_in), .mm_done(mm_done), .col_major(col_major),
        .base_addr(base_addr), .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .drain_busy(drain_busy), .drain_done(drain_done),
        .overrun(overrun), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // wr_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ~wr_ready;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: the words of a drain are fixed at the trigger; phase tracks
    // capture / streaming / done-pulse, m_n is the word currently offered.
    logic [31:0]   m_word [64];
    logic [AW-1:0] m_base;
    int            m_phase = 0;
    int            m_n = 0;
    logic [31:0]   m_sum = '0;
    bit            m_ovr = 1'b0;
    bit            m_prev = 1'b1;

    logic [31:0]   got_data [$];
    logic [AW-1:0] got_addr [$];
    bit            p_stall = 1'b0;
    logic [31:0]   p_data;
    logic [AW-1:0] p_addr;

    always @(negedge clk) begin : cmp
        bit            trig;
        int            old_phase;
        logic [AW-1:0] ea;
        if (!rst) begin
            m_phase = 0; m_n = 0; m_sum = '0; m_ovr = 1'b0; m_prev = 1'b1; p_stall = 1'b0;
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
        end
        chk("wr_valid", wr_valid, m_phase == 2);
        if (m_phase == 2) begin
            ea = m_base + AW'(m_n * 4);
            chk("wr_data", wr_data, m_word[m_n]);
            chk("wr_addr", wr_addr, ea);
        end
        chk("drain_busy", drain_busy, (m_phase == 1) || (m_phase == 2));
        chk("drain_done", drain_done, m_phase == 3);
        chk("overrun", overrun, m_ovr);
        chk("checksum", checksum, m_sum);
        if (p_stall) begin
            chk("stall_data", wr_data, p_data);
            chk("stall_addr", wr_addr, p_addr);
        end
        p_stall = wr_valid && !wr_ready;
        p_data  = wr_data;
        p_addr  = wr_addr;
        if (wr_valid && wr_ready) begin
            got_data.push_back(wr_data);
            got_addr.push_back(wr_addr);
        end
        if (rst) begin
            trig      = mm_done && !m_prev;
            m_prev    = mm_done;
            old_phase = m_phase;
            case (m_phase)
                0: if (trig) begin
                    for (int k = 0; k < 64; k++) begin
                        int elem;
                        elem = col_major ? (k % 8) * 8 + k / 8 : k;
                        m_word[k] = c_in[32*elem +: 32];
                    end
                    m_base  = base_addr;
                    m_n     = 0;
                    m_sum   = '0;
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: if (wr_ready) begin
                    m_sum = m_sum + m_word[m_n];
                    if (m_n == 63) m_phase = 3;
                    else m_n++;
                end
                default: m_phase = 0;
            endcase
            if (trig && old_phase != 0) m_ovr = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 64; k++) begin
            case (mode)
                0:       c_in[32*k +: 32] = 32'(k);
                1:       c_in[32*k +: 32] = 32'hFFFF_FFFF;
                default: c_in[32*k +: 32] = $urandom;
            endcase
        end
    endtask

    task automatic trigger(output int t);
        got_data.delete();
        got_addr.delete();
        mm_done = 1'b1;
        t = cyc + 1;
        step(1);
        mm_done = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int i;
        for (i = 0; i < 5000; i++) begin
            if (got_data.size() >= n) break;
            step(1);
        end
        if (i == 5000) chk("wait_words_timeout", got_data.size(), n);
    endtask

    task automatic wait_done(output int td);
        int i;
        td = -1;
        for (i = 0; i < 5000; i++) begin
            if (drain_done) begin
                td = cyc;
                break;
            end
            step(1);
        end
        if (i == 5000) chk("wait_done_timeout", 0, 1);
        step(2);
    endtask

    task automatic report(input string name, input int t, input int td);
        $display("drain %s: %0d words, checksum %08h, done at T+%0d",
                 name, got_data.size(), checksum, td - t);
    endtask

    int t, td, n0;

    initial begin
        // done already high at reset release: must not capture
        step(3);
        rst = 1'b1;
        step(6);
        chk("no_capture_busy", drain_busy, 0);
        chk("no_capture_valid", wr_valid, 0);
        mm_done = 1'b0;
        step(2);

        // row-major
        fill(0); base_addr = 16'h0100; col_major = 1'b0; ready_mode = 0;
        trigger(t); wait_done(td);
        report("row", t, td);
        chk("row_done_time", td, t + 65);
        chk("row_count", got_data.size(), 64);
        chk("row_checksum", checksum, 2016);
        chk("row_data5", got_data[5], 5);
        chk("row_addr63", got_addr[63], 16'h01FC);

        // column-major
        col_major = 1'b1;
        trigger(t); wait_done(td);
        report("col", t, td);
        chk("col_data1", got_data[1], 8);
        chk("col_data8", got_data[8], 1);
        chk("col_data63", got_data[63], 63);
        chk("col_addr9", got_addr[9], 16'h0124);
        chk("col_checksum", checksum, 2016);

        // all -1 with toggling ready
        fill(1); col_major = 1'b0; ready_mode = 1;
        trigger(t); wait_done(td);
        report("neg", t, td);
        chk("neg_count", got_data.size(), 64);
        chk("neg_data40", got_data[40], 32'hFFFF_FFFF);
        chk("neg_checksum", checksum, 32'hFFFF_FFC0);

        // second done edge mid-stream, and c_in changed afterwards
        fill(2); col_major = 1'($urandom_range(0, 1)); ready_mode = 2;
        trigger(t);
        wait_words(10);
        mm_done = 1'b1;
        step(1);
        mm_done = 1'b0;
        fill(2);
        wait_done(td);
        report("overrun", t, td);
        chk("ovr_flag", overrun, 1);
        chk("ovr_count", got_data.size(), 64);

        // address wrap
        fill(0); base_addr = 16'hFFF0; col_major = 1'b0; ready_mode = 0;
        trigger(t); wait_done(td);
        report("wrap", t, td);
        chk("wrap_addr3", got_addr[3], 16'hFFFC);
        chk("wrap_addr4", got_addr[4], 16'h0000);

        // reset mid-stream, then a fresh full drain
        base_addr = 16'h0200; ready_mode = 2;
        trigger(t);
        wait_words(30);
        rst = 1'b0;
        step(2);
        chk("midrst_valid", wr_valid, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_checksum", checksum, 0);
        rst = 1'b1;
        n0 = got_data.size();
        step(10);
        chk("midrst_no_words", got_data.size(), n0);
        trigger(t); wait_done(td);
        report("after_reset", t, td);
        chk("after_rst_count", got_data.size(), 64);
        chk("after_rst_addr0", got_addr[0], 16'h0200);

        // random drains
        for (int r = 0; r < 3; r++) begin
            fill(2); col_major = 1'($urandom_range(0, 1)); base_addr = AW'($urandom);
            trigger(t); wait_done(td);
            report("random", t, td);
            chk("rand_count", got_data.size(), 64);
        end

        step(2);
        chk("final_busy", drain_busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
